out_fm_store_ctrl: RTL and testbench



---
 rtl/out_fm_store_ctrl_if.sv | 35 +++
 rtl/out_fm_store_ctrl.sv | 145 ++++++++++++++
 tb/tb_out_fm_store_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/out_fm_store_ctrl_if.sv
// Tile-store handshake and write-master command bus between the scheduler/master side and
// the output feature map store controller.
interface out_fm_store_ctrl_if #(
  parameter int unsigned CW  = 16,
  parameter int unsigned XAW = 32
);
  logic           store_start;
  logic           store_done;
  logic [XAW-1:0] cfg_out_base;
  logic [CW-1:0]  cfg_n;
  logic [CW-1:0]  cfg_r;
  logic [CW-1:0]  cfg_c;
  logic [CW-1:0]  tile_base_n;
  logic [CW-1:0]  tile_base_row;
  logic [CW-1:0]  tile_base_col;
  logic [XAW-1:0] param_waddr;
  logic [CW-1:0]  param_iolen;
  logic           store_trans_start;
  logic           store_trans_done;
  logic           store_fifo_empty;

  modport master (
    input  store_start, cfg_out_base, cfg_n, cfg_r, cfg_c,
           tile_base_n, tile_base_row, tile_base_col,
           store_trans_done, store_fifo_empty,
    output store_done, param_waddr, param_iolen, store_trans_start
  );

  modport slave (
    output store_start, cfg_out_base, cfg_n, cfg_r, cfg_c,
           tile_base_n, tile_base_row, tile_base_col,
           store_trans_done, store_fifo_empty,
    input  store_done, param_waddr, param_iolen, store_trans_start
  );
endinterface

// File: rtl/out_fm_store_ctrl.sv
// Moves one output tile from the store FIFO to DDR as a sequence of write bursts,
// splitting each row into bursts of at most MAX_BURST words and clipping ragged edge tiles.
module out_fm_store_ctrl #(
  parameter int unsigned CW        = 16,
  parameter int unsigned DW        = 32,
  parameter int unsigned XAW       = 32,
  parameter int unsigned Tn        = 16,
  parameter int unsigned Tr        = 62,
  parameter int unsigned Tc        = 14,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  out_fm_store_ctrl_if.master bus
);
  localparam int unsigned BYTE_SHIFT = $clog2(DW / 8);
  localparam logic [CW-1:0] MB = CW'(MAX_BURST);

  typedef enum logic [2:0] {IDLE, CHECK, WAIT, CONFIG, TRANS, NEXT} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  vn, vr, vc;
  logic [CW-1:0]  base_n, base_row, base_col, cfg_r_q, cfg_c_q;
  logic [CW-1:0]  b, tr, tn;
  logic [XAW-1:0] out_base;
  logic           done_d, start_d;
  logic [CW-1:0]  burst_off, row_rem, iolen_c;
  logic           row_last, tile_last, tile_empty;
  logic [XAW-1:0] word_idx, waddr_c;

  // Valid extent along one dimension: zero when the origin lies at or past the edge.
  function automatic logic [CW-1:0] clip(input logic [CW-1:0] dim, input logic [CW-1:0] base,
                                         input logic [CW-1:0] lim);
    logic [CW-1:0] rem;
    rem = dim - base;
    if (base >= dim) return '0;
    return (rem > lim) ? lim : rem;
  endfunction

  always_comb begin
    burst_off  = b * MB;
    row_rem    = vc - burst_off;
    row_last   = (row_rem <= MB);
    iolen_c    = row_last ? row_rem : MB;
    tile_last  = row_last && (tr == vr - CW'(1)) && (tn == vn - CW'(1));
    tile_empty = (vn == '0) || (vr == '0) || (vc == '0);
    word_idx   = (XAW'(base_n) + XAW'(tn)) * XAW'(cfg_r_q) * XAW'(cfg_c_q)
               + (XAW'(base_row) + XAW'(tr)) * XAW'(cfg_c_q)
               + XAW'(base_col) + XAW'(burst_off);
    waddr_c    = out_base + (word_idx << BYTE_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    start_d = 1'b0;
    unique case (state)
      IDLE:   if (bus.store_start) state_d = CHECK;
      CHECK: begin
        if (tile_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT:   if (!bus.store_fifo_empty) state_d = CONFIG;
      CONFIG: begin
        start_d = 1'b1;
        state_d = TRANS;
      end
      TRANS:  if (bus.store_trans_done) state_d = NEXT;
      NEXT: begin
        if (tile_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tile latch, burst parameter registers and the burst/row/channel walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.store_done        <= 1'b0;
      bus.store_trans_start <= 1'b0;
      bus.param_waddr       <= '0;
      bus.param_iolen       <= '0;
      vn       <= '0;
      vr       <= '0;
      vc       <= '0;
      base_n   <= '0;
      base_row <= '0;
      base_col <= '0;
      cfg_r_q  <= '0;
      cfg_c_q  <= '0;
      out_base <= '0;
      b        <= '0;
      tr       <= '0;
      tn       <= '0;
    end else begin
      bus.store_done        <= done_d;
      bus.store_trans_start <= start_d;
      if (state == IDLE && bus.store_start) begin
        vn       <= clip(bus.cfg_n, bus.tile_base_n, CW'(Tn));
        vr       <= clip(bus.cfg_r, bus.tile_base_row, CW'(Tr));
        vc       <= clip(bus.cfg_c, bus.tile_base_col, CW'(Tc));
        base_n   <= bus.tile_base_n;
        base_row <= bus.tile_base_row;
        base_col <= bus.tile_base_col;
        cfg_r_q  <= bus.cfg_r;
        cfg_c_q  <= bus.cfg_c;
        out_base <= bus.cfg_out_base;
        b        <= '0;
        tr       <= '0;
        tn       <= '0;
      end
      if (state == CONFIG) begin
        bus.param_waddr <= waddr_c;
        bus.param_iolen <= iolen_c;
      end
      if (state == NEXT) begin
        if (!row_last) begin
          b <= b + CW'(1);
        end else begin
          b <= '0;
          if (tr == vr - CW'(1)) begin
            tr <= '0;
            tn <= tn + CW'(1);
          end else begin
            tr <= tr + CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_out_fm_store_ctrl.sv
// Directed self-checking bench for out_fm_store_ctrl: full tile, edge tile, empty tile,
// FIFO stall, reset abort and ignored stray handshakes.
module tb_out_fm_store_ctrl;
  localparam int unsigned CW  = 16;
  localparam int unsigned XAW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [XAW-1:0] wq[$];
  logic [XAW-1:0] ea[$];
  logic [CW-1:0]  lq[$];
  logic [CW-1:0]  el[$];

  always #5 clk = ~clk;

  out_fm_store_ctrl_if #(.CW(CW), .XAW(XAW)) bus ();

  out_fm_store_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference burst list for a tile, walked column-burst, row, channel.
  task automatic build_model(input int n, input int r, input int c, input int bn,
                             input int brow, input int bcol, input logic [31:0] base);
    int vn, vr, vc, nb;
    ea.delete();
    el.delete();
    vn = (bn >= n) ? 0 : ((n - bn > 16) ? 16 : n - bn);
    vr = (brow >= r) ? 0 : ((r - brow > 62) ? 62 : r - brow);
    vc = (bcol >= c) ? 0 : ((c - bcol > 14) ? 14 : c - bcol);
    nb = (vc + 7) / 8;
    for (int t_n = 0; t_n < vn; t_n++)
      for (int t_r = 0; t_r < vr; t_r++)
        for (int bb = 0; bb < nb; bb++) begin
          ea.push_back(base + 32'(((bn + t_n) * r * c + (brow + t_r) * c + bcol + bb * 8) * 4));
          el.push_back(16'((bb == nb - 1) ? vc - bb * 8 : 8));
        end
  endtask

  task automatic start_tile(input int n, input int r, input int c, input int bn,
                            input int brow, input int bcol, input logic [31:0] base);
    @(negedge clk);
    bus.cfg_n         = 16'(n);
    bus.cfg_r         = 16'(r);
    bus.cfg_c         = 16'(c);
    bus.tile_base_n   = 16'(bn);
    bus.tile_base_row = 16'(brow);
    bus.tile_base_col = 16'(bcol);
    bus.cfg_out_base  = base;
    bus.store_start   = 1'b1;
    @(negedge clk);
    bus.store_start   = 1'b0;
  endtask

  // Acts as the write master: records each burst and answers with trans_done.
  // With inject set, also pokes store_start in TRANS and trans_done in a held WAIT.
  task automatic serve(input int max_cycles, input bit inject, output int ncyc,
                       output bit got_done);
    int ph;
    ph = 0;
    got_done = 1'b0;
    ncyc = 0;
    wq.delete();
    lq.delete();
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      ncyc = i + 1;
      bus.store_trans_done = 1'b0;
      bus.store_start      = 1'b0;
      if (bus.store_done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.store_trans_start) begin
        wq.push_back(bus.param_waddr);
        lq.push_back(bus.param_iolen);
        bus.store_trans_done = 1'b1;
        if (inject) begin
          bus.store_start = 1'b1;
          ph = 1;
        end
      end else if (ph == 1) begin
        bus.store_fifo_empty = 1'b1;
        ph = 2;
      end else if (ph == 2) begin
        bus.store_trans_done = 1'b1;
        ph = 3;
      end else if (ph == 3) begin
        bus.store_fifo_empty = 1'b0;
        ph = 0;
      end
    end
    bus.store_trans_done = 1'b0;
    bus.store_start      = 1'b0;
    bus.store_fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.store_start = 1'b0;
    bus.store_trans_done = 1'b0;
    bus.store_fifo_empty = 1'b1;
    bus.cfg_out_base = '0;
    bus.cfg_n = '0;
    bus.cfg_r = '0;
    bus.cfg_c = '0;
    bus.tile_base_n = '0;
    bus.tile_base_row = '0;
    bus.tile_base_col = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.store_done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %0b want 0", bus.store_done);
    end
    checks++;
    if (bus.store_trans_start !== 1'b0) begin
      errors++; $display("FAIL reset_trans_start got %0b want 0", bus.store_trans_start);
    end
    checks++;
    if (bus.param_waddr !== 32'h0) begin
      errors++; $display("FAIL reset_waddr got %h want 0", bus.param_waddr);
    end
    checks++;
    if (bus.param_iolen !== 16'h0) begin
      errors++; $display("FAIL reset_iolen got %0d want 0", bus.param_iolen);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_tile();
    int  ncyc, nstart;
    bit  got;
    bus.store_fifo_empty = 1'b0;
    start_tile(32, 62, 30, 32, 0, 0, 32'h1000);
    serve(20, 1'b0, ncyc, got);
    checks++;
    if (!got || ncyc != 1) begin
      errors++; $display("FAIL zero_done_latency got done=%0b at %0d want 1 at 1", got, ncyc);
    end
    checks++;
    if (wq.size() != 0) begin
      errors++; $display("FAIL zero_no_trans got %0d bursts want 0", wq.size());
    end
    nstart = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.store_done || bus.store_trans_start) nstart++;
    end
    checks++;
    if (nstart != 0) begin
      errors++; $display("FAIL zero_quiet_after got %0d pulses want 0", nstart);
    end
  endtask

  task automatic test_fifo_wait();
    bus.store_fifo_empty = 1'b1;
    start_tile(32, 62, 30, 0, 0, 0, 32'h1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.store_trans_start !== 1'b0) begin
        errors++; $display("FAIL wait_no_start cycle %0d got %0b want 0", i, bus.store_trans_start);
      end
    end
    bus.store_fifo_empty = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.store_trans_start !== 1'b0) begin
      errors++; $display("FAIL wait_early_start got %0b want 0", bus.store_trans_start);
    end
    @(negedge clk);
    checks++;
    if (bus.store_trans_start !== 1'b1 || bus.param_waddr !== 32'h1000 || bus.param_iolen !== 16'd8) begin
      errors++;
      $display("FAIL wait_start_2cyc got start=%0b addr=%h len=%0d want 1 00001000 8",
               bus.store_trans_start, bus.param_waddr, bus.param_iolen);
    end
  endtask

  // Entered while the DUT is in TRANS from the stalled tile above.
  task automatic test_reset_abort();
    int pulses;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.store_trans_start !== 1'b0 || bus.store_done !== 1'b0 ||
        bus.param_waddr !== 32'h0 || bus.param_iolen !== 16'h0) begin
      errors++;
      $display("FAIL abort_outputs got start=%0b done=%0b addr=%h len=%0d want all 0",
               bus.store_trans_start, bus.store_done, bus.param_waddr, bus.param_iolen);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.store_done || bus.store_trans_start) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL abort_no_done got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_full_tile(input bit inject);
    int ncyc, nbad, extra;
    bit got;
    bus.store_fifo_empty = 1'b0;
    build_model(32, 62, 30, 0, 0, 0, 32'h1000);
    start_tile(32, 62, 30, 0, 0, 0, 32'h1000);
    if (inject) begin
      bus.cfg_n = 16'd1;
      bus.cfg_r = 16'd3;
      bus.cfg_c = 16'd5;
      bus.tile_base_col = 16'd7;
      bus.cfg_out_base = 32'hDEAD_0000;
    end
    serve(40000, inject, ncyc, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL full_done inject=%0b got no done within %0d cycles", inject, ncyc);
    end
    checks++;
    if (wq.size() != 1984) begin
      errors++; $display("FAIL full_count inject=%0b got %0d want 1984", inject, wq.size());
    end
    if (wq.size() >= 3) begin
      checks++;
      if (wq[0] !== 32'h1000 || wq[1] !== 32'h1020 || wq[2] !== 32'h1078) begin
        errors++;
        $display("FAIL full_first_addrs got %h %h %h want 00001000 00001020 00001078",
                 wq[0], wq[1], wq[2]);
      end
      checks++;
      if (lq[0] !== 16'd8 || lq[1] !== 16'd6 || lq[2] !== 16'd8) begin
        errors++; $display("FAIL full_first_lens got %0d %0d %0d want 8 6 8", lq[0], lq[1], lq[2]);
      end
    end
    nbad = 0;
    for (int i = 0; i < wq.size() && i < ea.size(); i++)
      if (wq[i] !== ea[i] || lq[i] !== el[i]) begin
        if (nbad == 0)
          $display("FAIL full_seq inject=%0b burst %0d got %h/%0d want %h/%0d",
                   inject, i, wq[i], lq[i], ea[i], el[i]);
        nbad++;
      end
    checks++;
    if (nbad != 0) errors++;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.store_done || bus.store_trans_start) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL full_single_done got %0d extra pulses want 0", extra);
    end
  endtask

  task automatic test_edge_tile();
    int ncyc, nbad;
    bit got;
    bus.store_fifo_empty = 1'b0;
    build_model(32, 62, 30, 24, 60, 28, 32'h1000);
    start_tile(32, 62, 30, 24, 60, 28, 32'h1000);
    serve(2000, 1'b0, ncyc, got);
    checks++;
    if (!got || wq.size() != 16) begin
      errors++; $display("FAIL edge_count got done=%0b bursts=%0d want 1 16", got, wq.size());
    end
    if (wq.size() > 0) begin
      checks++;
      if (wq[0] !== 32'd189968 || lq[0] !== 16'd2) begin
        errors++; $display("FAIL edge_first got %h/%0d want %h/2", wq[0], lq[0], 32'd189968);
      end
    end
    nbad = 0;
    for (int i = 0; i < wq.size() && i < ea.size(); i++)
      if (wq[i] !== ea[i] || lq[i] !== 16'd2) begin
        if (nbad == 0)
          $display("FAIL edge_seq burst %0d got %h/%0d want %h/2", i, wq[i], lq[i], ea[i]);
        nbad++;
      end
    checks++;
    if (nbad != 0) errors++;
  endtask

  initial begin
    test_reset();
    test_zero_tile();
    test_fifo_wait();
    test_reset_abort();
    test_full_tile(1'b0);
    test_edge_tile();
    test_full_tile(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
